pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS32 pipeline. It detects load-use hazards, redirects on EX-resolved taken branches/jumps, serialises the multi-cycle mult/div unit, and freezes the pipe on data-memory wait. It drives the enable, flush and load_use inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It also keeps saturating stall/flush statistics.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/md_busy_tracker.sv | 69 ++++++
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         MD_LATENCY_DEFAULT = 32;

endpackage

`default_nettype wire

// File: rtl/md_busy_tracker.sv
// ============================================================================
// Module  : md_busy_tracker
// Brief   : Tracks occupancy of the multi-cycle mult/div unit via a down-counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

import pipe_ctrl_pkg::*;

module md_busy_tracker #(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic frozen,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_MD_LOAD = CNT_W'(MD_LATENCY - 1);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter keeps running while the pipe is frozen; only issue is gated.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN: begin
                if (start && !frozen) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = c_MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (start && !frozen) begin
                    w_cnt_nxt = c_MD_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (r_state == MD_BUSY);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Stall/flush controller for the 5-stage pipeline with statistics.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_md_op,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              ex_branch_taken,
    input  logic              ex_md_start,
    input  logic              mem_wait,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              load_use,
    output logic              id_ex_flush,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    logic w_lu_haz;
    logic w_md_haz;
    logic r_unused;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_busy_tracker (
        .clk    (clk),
        .rst    (rst),
        .start  (ex_md_start),
        .frozen (mem_wait),
        .busy   (md_busy)
    );

    assign w_lu_haz = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((id_use_rs && (id_rs == ex_rt)) ||
                       (id_use_rt && (id_rt == ex_rt)));

    assign w_md_haz = id_md_op && (md_busy || ex_md_start);

    // A taken redirect outranks stalls: the ID instruction is wrong-path.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        load_use    = 1'b0;
        id_ex_flush = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_lu_haz || w_md_haz) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            load_use    = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((load_use || mem_wait) && (stall_cnt != {PERF_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (if_id_flush && (flush_cnt != {PERF_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_unused <= 1'b0;
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Directed, table-driven self-checking bench for pipe_hazard_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, load_use, id_ex_flush, md_busy}
    localparam logic [8:0] c_NORMAL   = 9'b11111_0_0_0_0;
    localparam logic [8:0] c_FREEZE   = 9'b00000_0_0_0_0;
    localparam logic [8:0] c_REDIRECT = 9'b11111_1_0_1_0;
    localparam logic [8:0] c_STALL    = 9'b00111_0_1_1_0;
    localparam logic [8:0] c_RESET    = 9'b00111_1_0_1_0;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_use_rs, id_use_rt, id_md_op, ex_mem_read;
    logic        ex_branch_taken, ex_md_start, mem_wait;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, load_use, id_ex_flush, md_busy;
    logic [15:0] stall_cnt, flush_cnt;
    logic [8:0]  outs;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       md_op;
        logic       mem_read;
        logic [4:0] ert;
        logic       br;
        logic       mwait;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MD_LATENCY (4),
        .CNT_W      (6),
        .PERF_W     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_md_op        (id_md_op),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .mem_wait        (mem_wait),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .load_use        (load_use),
        .id_ex_flush     (id_ex_flush),
        .md_busy         (md_busy),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, load_use, id_ex_flush, md_busy};

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic mdop,
                                input logic mrd, input logic [4:0] ert,
                                input logic br, input logic mw, input logic [8:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt; v.md_op = mdop;
        v.mem_read = mrd; v.ert = ert; v.br = br; v.mwait = mw; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_md_op = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
        ex_branch_taken = 1'b0; ex_md_start = 1'b0; mem_wait = 1'b0;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 0, c_NORMAL);
        vecs[1]  = mk(5'd8,  5'd0,  1, 0, 0, 1, 5'd8,  0, 0, c_STALL);
        vecs[2]  = mk(5'd0,  5'd0,  1, 1, 0, 1, 5'd0,  0, 0, c_NORMAL);
        vecs[3]  = mk(5'd8,  5'd0,  0, 0, 0, 1, 5'd8,  0, 0, c_NORMAL);
        vecs[4]  = mk(5'd3,  5'd17, 1, 1, 0, 1, 5'd17, 0, 0, c_STALL);
        vecs[5]  = mk(5'd8,  5'd8,  1, 1, 0, 0, 5'd8,  0, 0, c_NORMAL);
        vecs[6]  = mk(5'd8,  5'd0,  1, 0, 0, 1, 5'd8,  1, 0, c_REDIRECT);
        vecs[7]  = mk(5'd8,  5'd0,  1, 0, 0, 1, 5'd8,  1, 1, c_FREEZE);
        vecs[8]  = mk(5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  1, 0, c_REDIRECT);
        vecs[9]  = mk(5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 1, c_FREEZE);
        vecs[10] = mk(5'd0,  5'd0,  0, 0, 1, 0, 5'd0,  0, 0, c_NORMAL);
        vecs[11] = mk(5'd9,  5'd8,  1, 0, 0, 1, 5'd8,  0, 0, c_NORMAL);

        idle();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("reset_outputs", 32'(outs), 32'(c_RESET));
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_run_cycle", 32'(outs), 32'(c_NORMAL));

        // Single load-use stall, then a redirect that overrides the same hazard
        @(posedge clk); #1;
        set_lu();
        @(negedge clk);
        chk("lu_stall", 32'(outs), 32'(c_STALL));
        tick();
        idle();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        set_lu();
        ex_rt = 5'd0; id_rs = 5'd0;
        @(negedge clk);
        chk("lu_reg_zero", 32'(outs), 32'(c_NORMAL));
        tick();
        set_lu();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        chk("redirect_over_lu", 32'(outs), 32'(c_REDIRECT));
        tick();
        idle();
        chk("redirect_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("redirect_stall_cnt", 32'(stall_cnt), 32'd1);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
            id_md_op = vecs[i].md_op; ex_mem_read = vecs[i].mem_read;
            ex_rt = vecs[i].ert; ex_branch_taken = vecs[i].br;
            mem_wait = vecs[i].mwait; ex_md_start = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
            tick();
        end

        // Mult/div serialisation: busy for exactly 4 cycles after issue
        do_reset();
        ex_md_start = 1'b1;
        @(negedge clk);
        chk("md_issue", 32'(outs), 32'(c_NORMAL));
        tick();
        ex_md_start = 1'b0;
        id_md_op = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("md_stall_c%0d", c), 32'(outs), 32'(c_STALL | 9'd1));
            tick();
        end
        @(negedge clk);
        chk("md_release_c5", 32'(outs), 32'(c_NORMAL));
        tick();
        idle();

        // Freeze with a pending redirect while the mult/div unit counts down
        do_reset();
        ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0;
        mem_wait = 1'b1;
        ex_branch_taken = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("freeze_c%0d", c), 32'(outs), 32'(c_FREEZE | 9'd1));
            tick();
        end
        mem_wait = 1'b0;
        @(negedge clk);
        chk("freeze_then_redirect", 32'(outs), 32'(c_REDIRECT | 9'd1));
        tick();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        chk("freeze_md_done", 32'(outs), 32'(c_NORMAL));
        chk("freeze_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("freeze_flush_cnt", 32'(flush_cnt), 32'd1);
        tick();

        // Reset in the middle of a mult/div count
        do_reset();
        ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0;
        set_lu();
        @(negedge clk);
        chk("midbusy_lu", 32'(outs), 32'(c_STALL | 9'd1));
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("midbusy_rst_cycle", 32'(outs), 32'(c_RESET | 9'd1));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_normal", 32'(outs), 32'(c_NORMAL));
        chk("after_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("after_rst_flush_cnt", 32'(flush_cnt), 32'd0);
        tick();

        // Saturation of the stall counter
        do_reset();
        set_lu();
        repeat (65534) @(posedge clk);
        #1;
        chk("stall_cnt_fffe", 32'(stall_cnt), 32'h0000_FFFE);
        repeat (70000 - 65534) @(posedge clk);
        #1;
        chk("stall_cnt_saturated", 32'(stall_cnt), 32'h0000_FFFF);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
